lcd_text_driver: RTL and testbench

LCD_TEXT_DRIVER -- requirements
Module: lcd_text_driver

---
 rtl/lcd_text_driver.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_lcd_text_driver.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_driver.sv
// -----------------------------------------------------------------------------
// lcd_text_driver
//
// Drives a 2x16 HD44780-style character LCD over its 8-bit bus. After a
// power-on wait it sends the init commands 0x38, 0x0C, 0x06, 0x01, then writes
// both text rows whenever a refresh is pending. Row text is captured into a
// snapshot when a frame starts, so input changes mid-frame do not tear it.
//
// Every bus byte is one transaction:
//   setup  (1 cycle, lcd_e=0, rs/data valid)
//   strobe (E_HIGH_CYC cycles, lcd_e=1)
//   wait   (CMD_GAP_CYC cycles, or CLEAR_WAIT_CYC after command 0x01)
// rs/data are held stable for the whole transaction.
//
// Parameters:
//   POWERUP_CYC    power-on wait in clk cycles
//   E_HIGH_CYC     lcd_e high width in cycles
//   CMD_GAP_CYC    post-strobe wait for ordinary bytes
//   CLEAR_WAIT_CYC post-strobe wait after the clear command 0x01
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   line1        row-0 text, [127:120] = column 0 ... [7:0] = column 15
//   line2        row-1 text, same byte order
//   refresh_req  single-cycle request to rewrite both rows
//   lcd_e        enable strobe
//   lcd_rs       register select (0 = command, 1 = data)
//   lcd_rw        read/write select, always 0 (write only)
//   lcd_data     8-bit bus byte
//   init_done    high once the init sequence has completed, until rst
//   busy         high in every state except IDLE
//   frame_done   one-cycle pulse when a full two-row frame has finished
//
// Build option:
//   LCD_CHANGE_DETECT_EN  when defined, IDLE compares {line1,line2} with the
//                         snapshot and schedules a refresh on any difference.
//                         When undefined no comparator exists and frames start
//                         only after init or on refresh_req.
// -----------------------------------------------------------------------------
module lcd_text_driver #(
  parameter int unsigned POWERUP_CYC    = 1000000,
  parameter int unsigned E_HIGH_CYC     = 25,
  parameter int unsigned CMD_GAP_CYC    = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] line1,
  input  logic [127:0] line2,
  input  logic         refresh_req,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         busy,
  output logic         frame_done
);

  // Counter is sized for the largest wait so no count can wrap.
  localparam int unsigned MAX_A   = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
  localparam int unsigned MAX_B   = (CMD_GAP_CYC > E_HIGH_CYC) ? CMD_GAP_CYC : E_HIGH_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] EH_LAST  = CW'(E_HIGH_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CMD_GAP_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_WAIT_CYC - 1);

  // Top-level states
  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_ADDR1 = 3'd3;
  localparam logic [2:0] S_WR1   = 3'd4;
  localparam logic [2:0] S_ADDR2 = 3'd5;
  localparam logic [2:0] S_WR2   = 3'd6;

  // Phases of one bus byte
  localparam logic [1:0] P_SETUP  = 2'd0;
  localparam logic [1:0] P_STROBE = 2'd1;
  localparam logic [1:0] P_WAIT   = 2'd2;

  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;
  localparam logic [7:0] CMD_CLEAR = 8'h01;

  logic [2:0]    r_state;
  logic [1:0]    r_phase;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_idx;
  logic          r_lcd_e;
  logic          r_lcd_rs;
  logic [7:0]    r_lcd_data;
  logic          r_init_done;
  logic          r_frame_done;
  logic          r_pending;
  logic [127:0]  r_snap1;
  logic [127:0]  r_snap2;

  logic [CW-1:0] w_wait_last;
  logic [2:0]    w_nxt_state;
  logic [3:0]    w_nxt_idx;
  logic          w_nxt_rs;
  logic [7:0]    w_nxt_data;

  // Column c of a row: column 0 lives in the top byte, so the byte offset is 15-c.
  function automatic logic [7:0] f_col(input logic [127:0] row, input logic [3:0] c);
    f_col = row[{~c, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] f_init_cmd(input logic [3:0] i);
    case (i)
      4'd0:    f_init_cmd = 8'h38;
      4'd1:    f_init_cmd = 8'h0C;
      4'd2:    f_init_cmd = 8'h06;
      default: f_init_cmd = CMD_CLEAR;
    endcase
  endfunction

  // Only the clear command earns the long wait; a data byte of 0x01 does not.
  assign w_wait_last = (!r_lcd_rs && (r_lcd_data == CMD_CLEAR)) ? CLR_LAST : GAP_LAST;

  // What to send once the current byte's wait expires.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx + 4'd1;
    w_nxt_rs    = 1'b1;
    w_nxt_data  = 8'h00;
    case (r_state)
      S_INIT: begin
        if (r_idx == 4'd3) begin
          w_nxt_state = S_IDLE;
          w_nxt_idx   = '0;
        end else begin
          w_nxt_rs   = 1'b0;
          w_nxt_data = f_init_cmd(r_idx + 4'd1);
        end
      end
      S_ADDR1: begin
        w_nxt_state = S_WR1;
        w_nxt_idx   = '0;
        w_nxt_data  = f_col(r_snap1, 4'd0);
      end
      S_WR1: begin
        if (r_idx == 4'd15) begin
          w_nxt_state = S_ADDR2;
          w_nxt_idx   = '0;
          w_nxt_rs    = 1'b0;
          w_nxt_data  = CMD_LINE2;
        end else begin
          w_nxt_data = f_col(r_snap1, r_idx + 4'd1);
        end
      end
      S_ADDR2: begin
        w_nxt_state = S_WR2;
        w_nxt_idx   = '0;
        w_nxt_data  = f_col(r_snap2, 4'd0);
      end
      S_WR2: begin
        if (r_idx == 4'd15) begin
          w_nxt_state = S_IDLE;
          w_nxt_idx   = '0;
        end else begin
          w_nxt_data = f_col(r_snap2, r_idx + 4'd1);
        end
      end
      default: ;
    endcase
  end

`ifdef LCD_CHANGE_DETECT_EN
  logic w_changed;
  assign w_changed = ({line1, line2} != {r_snap1, r_snap2});
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_PWRUP;
      r_phase      <= P_SETUP;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_lcd_e      <= 1'b0;
      r_lcd_rs     <= 1'b0;
      r_lcd_data   <= 8'h00;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_pending    <= 1'b0;
      r_snap1      <= {16{8'h20}};
      r_snap2      <= {16{8'h20}};
    end else begin
      r_frame_done <= 1'b0;
      if (refresh_req) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        S_PWRUP: begin
          if (r_cnt == PWR_LAST) begin
            r_state    <= S_INIT;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_phase    <= P_SETUP;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= f_init_cmd(4'd0);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_IDLE: begin
          if (r_pending) begin
            // A request landing in this very cycle must survive the clear,
            // so it re-arms pending for a second frame.
            r_snap1    <= line1;
            r_snap2    <= line2;
            r_pending  <= refresh_req;
            r_state    <= S_ADDR1;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_phase    <= P_SETUP;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= CMD_LINE1;
          end
`ifdef LCD_CHANGE_DETECT_EN
          else if (w_changed) begin
            r_pending <= 1'b1;
          end
`endif
        end

        default: begin
          case (r_phase)
            P_SETUP: begin
              r_lcd_e <= 1'b1;
              r_phase <= P_STROBE;
              r_cnt   <= '0;
            end
            P_STROBE: begin
              if (r_cnt == EH_LAST) begin
                r_lcd_e <= 1'b0;
                r_phase <= P_WAIT;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            default: begin
              if (r_cnt == w_wait_last) begin
                r_state <= w_nxt_state;
                r_idx   <= w_nxt_idx;
                r_cnt   <= '0;
                r_phase <= P_SETUP;
                if (w_nxt_state == S_IDLE) begin
                  if (r_state == S_INIT) begin
                    r_init_done <= 1'b1;
                    r_pending   <= 1'b1;
                  end else begin
                    r_frame_done <= 1'b1;
                  end
                end else begin
                  r_lcd_rs   <= w_nxt_rs;
                  r_lcd_data <= w_nxt_data;
                end
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          endcase
        end
      endcase
    end
  end

  assign lcd_e      = r_lcd_e;
  assign lcd_rs     = r_lcd_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = r_lcd_data;
  assign init_done  = r_init_done;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_text_driver.sv
// -----------------------------------------------------------------------------
// tb_lcd_text_driver
//
// Directed bench for lcd_text_driver with short timing parameters
// (POWERUP 10, E high 2, gap 4, clear wait 8). A monitor logs every lcd_e
// rising edge ({rs,data} and cycle), frame_done pulses and init_done rises;
// scenario tasks compare those logs with hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_lcd_text_driver;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] line1 = '0;
  logic [127:0] line2 = '0;
  logic         refresh_req = 1'b0;
  logic         lcd_e;
  logic         lcd_rs;
  logic         lcd_rw;
  logic [7:0]   lcd_data;
  logic         init_done;
  logic         busy;
  logic         frame_done;

  lcd_text_driver #(
    .POWERUP_CYC   (10),
    .E_HIGH_CYC    (2),
    .CMD_GAP_CYC   (4),
    .CLEAR_WAIT_CYC(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .line1      (line1),
    .line2      (line2),
    .refresh_req(refresh_req),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_data   (lcd_data),
    .init_done  (init_done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int g_rel    = 0;

  // Monitor: posedge count plus logs sampled 2 time units after each edge.
  int         cyc = 0;
  logic [8:0] st_b[$];
  int         st_c[$];
  int         fd_c[$];
  int         id_c[$];
  int         hold_err = 0;
  logic       prev_e = 1'b0;
  logic       prev_id = 1'b0;
  logic [7:0] held = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (lcd_e === 1'b1 && prev_e !== 1'b1) begin
      st_b.push_back({lcd_rs, lcd_data});
      st_c.push_back(cyc);
      held = lcd_data;
    end else if (lcd_e === 1'b1 && lcd_data !== held) begin
      hold_err++;
    end
    if (frame_done === 1'b1) fd_c.push_back(cyc);
    if (init_done === 1'b1 && prev_id !== 1'b1) id_c.push_back(cyc);
    prev_e  = lcd_e;
    prev_id = init_done;
  end

  // Expected {rs,data} at position k (0..33) of a frame.
  function automatic logic [8:0] exp_byte(input logic [127:0] a, input logic [127:0] b, input int k);
    if (k == 0)       exp_byte = {1'b0, 8'h80};
    else if (k <= 16) exp_byte = {1'b1, a[(16 - k) * 8 +: 8]};
    else if (k == 17) exp_byte = {1'b0, 8'hC0};
    else              exp_byte = {1'b1, b[(33 - k) * 8 +: 8]};
  endfunction

  function automatic logic [8:0] st_at(input int i);
    st_at = (i < st_b.size()) ? st_b[i] : 9'h1FF;
  endfunction

  function automatic int stc_at(input int i);
    stc_at = (i < st_c.size()) ? st_c[i] : -1;
  endfunction

  function automatic int fdc_at(input int i);
    fdc_at = (i < fd_c.size()) ? fd_c[i] : -1;
  endfunction

  function automatic int idc_at(input int i);
    idc_at = (i < id_c.size()) ? id_c[i] : -1;
  endfunction

  task automatic pulse_refresh();
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (lcd_e !== 1'b0)       begin n_fail++; $display("FAIL reset_lcd_e: got %b expected 0", lcd_e); end
    n_checks++; if (lcd_rs !== 1'b0)      begin n_fail++; $display("FAIL reset_lcd_rs: got %b expected 0", lcd_rs); end
    n_checks++; if (lcd_rw !== 1'b0)      begin n_fail++; $display("FAIL reset_lcd_rw: got %b expected 0", lcd_rw); end
    n_checks++; if (lcd_data !== 8'h00)   begin n_fail++; $display("FAIL reset_lcd_data: got %h expected 00", lcd_data); end
    n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
    n_checks++; if (init_done !== 1'b0)   begin n_fail++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    n_checks++; if (frame_done !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
  endtask

  task automatic test_init();
    int sb, ib;
    logic [7:0] cmds [4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
    line1 = "PRESS * TO START";
    line2 = "MONEY: 01000    ";
    sb = st_b.size();
    ib = id_c.size();
    g_rel = cyc;
    rst = 1'b0;
    for (int i = 0; i < 100 && id_c.size() <= ib; i++) @(negedge clk);
    n_checks++; if (id_c.size() <= ib) begin n_fail++; $display("FAIL init_timeout: init_done never rose"); end
    n_checks++; if (stc_at(sb) !== g_rel + 11) begin n_fail++; $display("FAIL init_first_e: got cycle %0d expected %0d", stc_at(sb) - g_rel, 11); end
    n_checks++; if (st_b.size() - sb !== 4) begin n_fail++; $display("FAIL init_count: got %0d strobes expected 4", st_b.size() - sb); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (st_at(sb + k) !== {1'b0, cmds[k]}) begin
        n_fail++; $display("FAIL init_byte%0d: got %h expected %h", k, st_at(sb + k), {1'b0, cmds[k]});
      end
    end
    for (int k = 1; k < 4; k++) begin
      n_checks++;
      if (stc_at(sb + k) - stc_at(sb + k - 1) !== 7) begin
        n_fail++; $display("FAIL init_spacing%0d: got %0d expected 7", k, stc_at(sb + k) - stc_at(sb + k - 1));
      end
    end
    n_checks++; if (idc_at(ib) !== g_rel + 42) begin n_fail++; $display("FAIL init_done_time: got %0d expected %0d", idc_at(ib) - g_rel, 42); end
  endtask

  task automatic test_frame();
    int sb, fb;
    sb = st_b.size();
    fb = fd_c.size();
    for (int i = 0; i < 400 && fd_c.size() <= fb; i++) @(negedge clk);
    n_checks++; if (fd_c.size() <= fb) begin n_fail++; $display("FAIL frame_timeout: no frame_done"); end
    n_checks++; if (st_b.size() - sb !== 34) begin n_fail++; $display("FAIL frame_count: got %0d expected 34", st_b.size() - sb); end
    for (int k = 0; k < 34; k++) begin
      n_checks++;
      if (st_at(sb + k) !== exp_byte(line1, line2, k)) begin
        n_fail++; $display("FAIL frame_byte%0d: got %h expected %h", k, st_at(sb + k), exp_byte(line1, line2, k));
      end
    end
    n_checks++; if (stc_at(sb) !== g_rel + 44) begin n_fail++; $display("FAIL frame_first_e: got %0d expected 44", stc_at(sb) - g_rel); end
    n_checks++; if (fdc_at(fb) !== g_rel + 281) begin n_fail++; $display("FAIL frame_done_time: got %0d expected 281", fdc_at(fb) - g_rel); end
    @(negedge clk);
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_width: got %b expected 0", frame_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_idle();
    int sb, fb, bad;
    sb = st_b.size();
    fb = fd_c.size();
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (busy !== 1'b0 || lcd_e !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_quiet: got %0d busy/e cycles expected 0", bad); end
    n_checks++; if (st_b.size() !== sb) begin n_fail++; $display("FAIL idle_strobes: got %0d expected 0", st_b.size() - sb); end
    n_checks++; if (fd_c.size() !== fb) begin n_fail++; $display("FAIL idle_frames: got %0d expected 0", fd_c.size() - fb); end
  endtask

  task automatic test_snapshot();
    int sb, fb;
    logic [127:0] old1;
    old1 = line1;
    sb = st_b.size();
    fb = fd_c.size();
    pulse_refresh();
    for (int i = 0; i < 200 && st_b.size() - sb < 7; i++) @(negedge clk);
    line1 = "INSERT COIN NOW!";
    for (int i = 0; i < 400 && fd_c.size() <= fb; i++) @(negedge clk);
    n_checks++; if (fd_c.size() <= fb) begin n_fail++; $display("FAIL snap_timeout: no frame_done"); end
    for (int k = 0; k < 34; k++) begin
      n_checks++;
      if (st_at(sb + k) !== exp_byte(old1, line2, k)) begin
        n_fail++; $display("FAIL snap_byte%0d: got %h expected %h", k, st_at(sb + k), exp_byte(old1, line2, k));
      end
    end
`ifdef LCD_CHANGE_DETECT_EN
    for (int i = 0; i < 600 && fd_c.size() <= fb + 1; i++) @(negedge clk);
    n_checks++; if (fd_c.size() !== fb + 2) begin n_fail++; $display("FAIL snap_auto_frame: got %0d frames expected 2", fd_c.size() - fb); end
    for (int k = 0; k < 34; k++) begin
      n_checks++;
      if (st_at(sb + 34 + k) !== exp_byte(line1, line2, k)) begin
        n_fail++; $display("FAIL snap_new_byte%0d: got %h expected %h", k, st_at(sb + 34 + k), exp_byte(line1, line2, k));
      end
    end
`else
    repeat (300) @(negedge clk);
    n_checks++; if (fd_c.size() !== fb + 1) begin n_fail++; $display("FAIL snap_no_second: got %0d frames expected 1", fd_c.size() - fb); end
    n_checks++; if (st_b.size() - sb !== 34) begin n_fail++; $display("FAIL snap_strobes: got %0d expected 34", st_b.size() - sb); end
`endif
  endtask

  task automatic test_multi_req();
    int sb, fb;
    sb = st_b.size();
    fb = fd_c.size();
    // Row 2 carries control-range and high-bit bytes that must pass unmodified.
    line2 = {8'h00, 8'h1F, 8'h80, 8'hFF, "ABCDEFGHIJKL"};
    pulse_refresh();
    for (int i = 0; i < 200 && st_b.size() - sb < 5; i++) @(negedge clk);
    repeat (3) begin
      pulse_refresh();
      repeat (3) @(negedge clk);
    end
    for (int i = 0; i < 900 && fd_c.size() < fb + 2; i++) @(negedge clk);
    repeat (300) @(negedge clk);
    n_checks++; if (fd_c.size() !== fb + 2) begin n_fail++; $display("FAIL multi_frames: got %0d expected 2", fd_c.size() - fb); end
    n_checks++; if (st_b.size() - sb !== 68) begin n_fail++; $display("FAIL multi_strobes: got %0d expected 68", st_b.size() - sb); end
    for (int k = 0; k < 68; k++) begin
      n_checks++;
      if (st_at(sb + k) !== exp_byte(line1, line2, k % 34)) begin
        n_fail++; $display("FAIL multi_byte%0d: got %h expected %h", k, st_at(sb + k), exp_byte(line1, line2, k % 34));
      end
    end
  endtask

  task automatic test_back_to_back();
    int sb, fb;
    sb = st_b.size();
    fb = fd_c.size();
    // Second cycle of the request coincides with frame start.
    refresh_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    refresh_req = 1'b0;
    for (int i = 0; i < 900 && fd_c.size() < fb + 2; i++) @(negedge clk);
    repeat (300) @(negedge clk);
    n_checks++; if (fd_c.size() !== fb + 2) begin n_fail++; $display("FAIL b2b_frames: got %0d expected 2", fd_c.size() - fb); end
    n_checks++; if (fdc_at(fb + 1) - fdc_at(fb) !== 239) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 239", fdc_at(fb + 1) - fdc_at(fb)); end
    n_checks++; if (st_b.size() - sb !== 68) begin n_fail++; $display("FAIL b2b_strobes: got %0d expected 68", st_b.size() - sb); end
  endtask

  task automatic test_reset_mid();
    int sb, ib;
    logic found;
    sb = st_b.size();
    pulse_refresh();
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (st_b.size() - sb >= 19 && lcd_e === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL mid_find_wr2: lcd_e high in WR2 not seen"); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (lcd_e !== 1'b0)      begin n_fail++; $display("FAIL mid_lcd_e: got %b expected 0", lcd_e); end
    n_checks++; if (lcd_data !== 8'h00)  begin n_fail++; $display("FAIL mid_lcd_data: got %h expected 00", lcd_data); end
    n_checks++; if (lcd_rs !== 1'b0)     begin n_fail++; $display("FAIL mid_lcd_rs: got %b expected 0", lcd_rs); end
    n_checks++; if (init_done !== 1'b0)  begin n_fail++; $display("FAIL mid_init_done: got %b expected 0", init_done); end
    n_checks++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_frame_done: got %b expected 0", frame_done); end
    sb = st_b.size();
    ib = id_c.size();
    g_rel = cyc;
    rst = 1'b0;
    for (int i = 0; i < 100 && id_c.size() <= ib; i++) @(negedge clk);
    n_checks++; if (stc_at(sb) !== g_rel + 11) begin n_fail++; $display("FAIL mid_rerun_first_e: got %0d expected 11", stc_at(sb) - g_rel); end
    n_checks++; if (st_at(sb) !== 9'h038) begin n_fail++; $display("FAIL mid_rerun_byte: got %h expected 038", st_at(sb)); end
    n_checks++; if (st_b.size() - sb !== 4) begin n_fail++; $display("FAIL mid_rerun_count: got %0d expected 4", st_b.size() - sb); end
    n_checks++; if (idc_at(ib) !== g_rel + 42) begin n_fail++; $display("FAIL mid_rerun_done: got %0d expected 42", idc_at(ib) - g_rel); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_frame();
    test_idle();
    test_snapshot();
    test_multi_req();
    test_back_to_back();
    test_reset_mid();
    n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL data_hold: got %0d changes while lcd_e high expected 0", hold_err); end
    n_checks++; if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL rw_tied: got %b expected 0", lcd_rw); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
